// File: rtl/ula_pkg.sv
// Shared definitions for the ula_8bit ALU: mode constants and function-select codes.
package ula_pkg;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Names follow the arithmetic-mode meaning of each code.
  typedef enum logic [3:0] {
    FN_A           = 4'b0000,
    FN_A_OR_B      = 4'b0001,
    FN_A_OR_NB     = 4'b0010,
    FN_ONES        = 4'b0011,
    FN_A_PLUS_ANB  = 4'b0100,
    FN_ADD         = 4'b0101,
    FN_ADD_NB      = 4'b0110,
    FN_ANB_DEC     = 4'b0111,
    FN_SUB         = 4'b1000,
    FN_DBL         = 4'b1001,
    FN_AORB_PLUS_A = 4'b1010,
    FN_AB_DEC      = 4'b1011,
    FN_B           = 4'b1100,
    FN_AB_PLUS_A   = 4'b1101,
    FN_RSUB        = 4'b1110,
    FN_DEC         = 4'b1111
  } ula_fn_e;

endpackage

// File: rtl/ula_slice_4.sv
// Combinational 4-bit ALU slice: operand selection, logic functions and 4-bit add
// with carry-out and the carry into the slice MSB.
module ula_slice_4
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  ula_fn_e    s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       c_msb
);

  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] lf;
  logic [3:0] sum_lo;
  logic [1:0] sum_hi;

  // Every arithmetic function is reduced to X + Y + carry.
  always_comb begin
    x = a;
    y = 4'h0;
    unique case (s)
      FN_A:           begin x = a;      y = 4'h0;  end
      FN_A_OR_B:      begin x = a | b;  y = 4'h0;  end
      FN_A_OR_NB:     begin x = a | ~b; y = 4'h0;  end
      FN_ONES:        begin x = 4'h0;   y = 4'hF;  end
      FN_A_PLUS_ANB:  begin x = a;      y = a & ~b; end
      FN_ADD:         begin x = a;      y = b;     end
      FN_ADD_NB:      begin x = a;      y = ~b;    end
      FN_ANB_DEC:     begin x = a & ~b; y = 4'hF;  end
      FN_SUB:         begin x = a;      y = ~b;    end
      FN_DBL:         begin x = a;      y = a;     end
      FN_AORB_PLUS_A: begin x = a | b;  y = a;     end
      FN_AB_DEC:      begin x = a & b;  y = 4'hF;  end
      FN_B:           begin x = b;      y = 4'h0;  end
      FN_AB_PLUS_A:   begin x = a & b;  y = a;     end
      FN_RSUB:        begin x = b;      y = ~a;    end
      FN_DEC:         begin x = a;      y = 4'hF;  end
      default:        begin x = a;      y = 4'h0;  end
    endcase
  end

  always_comb begin
    lf = ~a;
    unique case (s)
      4'b0000: lf = ~a;
      4'b0001: lf = ~(a | b);
      4'b0010: lf = ~a & b;
      4'b0011: lf = 4'h0;
      4'b0100: lf = ~(a & b);
      4'b0101: lf = ~b;
      4'b0110: lf = a ^ b;
      4'b0111: lf = a & ~b;
      4'b1000: lf = ~a | b;
      4'b1001: lf = ~(a ^ b);
      4'b1010: lf = b;
      4'b1011: lf = a & b;
      4'b1100: lf = 4'hF;
      4'b1101: lf = a | ~b;
      4'b1110: lf = a | b;
      4'b1111: lf = a;
      default: lf = ~a;
    endcase
  end

  // Split the add at the MSB so the carry into it is visible for overflow.
  assign sum_lo = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, c_in};
  assign sum_hi = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, sum_lo[3]};

  assign c_msb = sum_lo[3];
  assign c_out = sum_hi[1];
  assign f     = (m == MODE_LOGIC) ? lf : {sum_hi[0], sum_lo[2:0]};

endmodule

// File: rtl/ula_8bit.sv
// 8-bit ALU built from two ripple-carried 4-bit slices, all outputs registered.
// Define ULA_OVERFLOW_EN to compute the signed overflow flag; otherwise it is tied to 0.
module ula_8bit
  import ula_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       a_eq_b,
  output logic       c_out,
  output logic       overflow
);

  ula_fn_e    fn;
  logic       k;
  logic       lo_c_out;
  logic       lo_c_msb_unused;
  logic       hi_c_out;
  logic       hi_c_msb;
  logic [7:0] f_p0;
  logic       c_out_p0;
  logic       eq_p0;

  assign fn = ula_fn_e'(s);
  // Subtractions need the +1 of two's complement regardless of c_in.
  assign k  = (fn == FN_SUB || fn == FN_RSUB) ? 1'b1 : c_in;

  ula_slice_4 u_lo (
    .a     (a[3:0]),
    .b     (b[3:0]),
    .s     (fn),
    .m     (m),
    .c_in  (k),
    .f     (f_p0[3:0]),
    .c_out (lo_c_out),
    .c_msb (lo_c_msb_unused)
  );

  ula_slice_4 u_hi (
    .a     (a[7:4]),
    .b     (b[7:4]),
    .s     (fn),
    .m     (m),
    .c_in  (lo_c_out),
    .f     (f_p0[7:4]),
    .c_out (hi_c_out),
    .c_msb (hi_c_msb)
  );

  assign c_out_p0 = (m == MODE_ARITH) & hi_c_out;
  assign eq_p0    = (a == b);

  // Stage p0 -> registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f      <= 8'h00;
      a_eq_b <= 1'b0;
      c_out  <= 1'b0;
    end else begin
      f      <= f_p0;
      a_eq_b <= eq_p0;
      c_out  <= c_out_p0;
    end
  end

`ifdef ULA_OVERFLOW_EN
  logic ovf_p0;

  assign ovf_p0 = (m == MODE_ARITH) & (hi_c_msb ^ hi_c_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= ovf_p0;
  end
`else
  logic ovf_unused;

  assign ovf_unused = hi_c_msb;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_ula_8bit.sv
// Directed-vector bench for ula_8bit; overflow expectations follow ULA_OVERFLOW_EN.
module tb_ula_8bit;
  import ula_pkg::*;

`ifdef ULA_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [3:0] s;
  logic       m, c_in;
  logic [7:0] f;
  logic       a_eq_b, c_out, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  ula_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .s        (s),
    .m        (m),
    .c_in     (c_in),
    .f        (f),
    .a_eq_b   (a_eq_b),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one vector, then sample #1 after the capturing edge.
  task automatic apply(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts,
                       input logic tm, input logic tc);
    a = ta; b = tb; s = ts; m = tm; c_in = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_arith(input string tag, input logic [7:0] ef, input logic ec, input logic eo);
    chk({tag, ".f"}, f, ef);
    chk({tag, ".c_out"}, {7'b0, c_out}, {7'b0, ec});
    chk({tag, ".ovf"}, {7'b0, overflow}, {7'b0, eo & OVF_EN});
  endtask

  logic [7:0] logic_exp [16];

  initial begin
    logic_exp = '{8'h0F, 8'h03, 8'h0C, 8'h00, 8'hCF, 8'hC3, 8'hCC, 8'hC0,
                  8'h3F, 8'h33, 8'h3C, 8'h30, 8'hFF, 8'hF3, 8'hFC, 8'hF0};
    rst_n = 1'b0;
    a = 8'h00; b = 8'h00; s = 4'h0; m = 1'b0; c_in = 1'b0;
    #12;
    chk("rst.f", f, 8'h00);
    chk("rst.eq", {7'b0, a_eq_b}, 8'h00);
    chk("rst.c_out", {7'b0, c_out}, 8'h00);
    chk("rst.ovf", {7'b0, overflow}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Addition
    apply(8'h01, 8'h02, 4'b0101, 1'b0, 1'b0); chk_arith("add01_02", 8'h03, 1'b0, 1'b0);
    apply(8'h0F, 8'h01, 4'b0101, 1'b0, 1'b0); chk_arith("add0F_01", 8'h10, 1'b0, 1'b0);
    apply(8'h7F, 8'h01, 4'b0101, 1'b0, 1'b0); chk_arith("add7F_01", 8'h80, 1'b0, 1'b1);
    apply(8'hFF, 8'h01, 4'b0101, 1'b0, 1'b0); chk_arith("addFF_01", 8'h00, 1'b1, 1'b0);
    apply(8'h10, 8'h20, 4'b0101, 1'b0, 1'b1); chk_arith("add_cin",  8'h31, 1'b0, 1'b0);

    // Subtraction ignores c_in
    apply(8'h0A, 8'h05, 4'b1000, 1'b0, 1'b0); chk_arith("sub0A_05", 8'h05, 1'b1, 1'b0);
    apply(8'h05, 8'h0A, 4'b1000, 1'b0, 1'b0); chk_arith("sub05_0A", 8'hFB, 1'b0, 1'b0);
    apply(8'h80, 8'h01, 4'b1000, 1'b0, 1'b0); chk_arith("sub80_01", 8'h7F, 1'b1, 1'b1);
    apply(8'h0A, 8'h05, 4'b1000, 1'b0, 1'b1); chk_arith("sub_cin1", 8'h05, 1'b1, 1'b0);

    // Other arithmetic codes
    apply(8'h0A, 8'h05, 4'b0110, 1'b0, 1'b0); chk_arith("addnb_c0", 8'h04, 1'b1, 1'b0);
    apply(8'h05, 8'h0A, 4'b1110, 1'b0, 1'b0); chk_arith("rsub",     8'h05, 1'b1, 1'b0);
    apply(8'h00, 8'h33, 4'b1111, 1'b0, 1'b0); chk_arith("dec00",    8'hFF, 1'b0, 1'b0);
    apply(8'h81, 8'h00, 4'b1001, 1'b0, 1'b0); chk_arith("dbl81",    8'h02, 1'b1, 1'b1);
    apply(8'h12, 8'h34, 4'b1100, 1'b0, 1'b0); chk_arith("passB",    8'h34, 1'b0, 1'b0);

    // Equality
    apply(8'h55, 8'h55, 4'b0000, 1'b1, 1'b0); chk("eq55_55", {7'b0, a_eq_b}, 8'h01);
    apply(8'h55, 8'h54, 4'b0000, 1'b1, 1'b0); chk("eq55_54", {7'b0, a_eq_b}, 8'h00);
    apply(8'h55, 8'hD5, 4'b0101, 1'b0, 1'b1); chk("eq55_D5", {7'b0, a_eq_b}, 8'h00);

    // Logic mode, every code; carries forced low even with c_in set
    for (int i = 0; i < 16; i++) begin
      apply(8'hF0, 8'h3C, 4'(i), 1'b1, 1'b1);
      chk($sformatf("logic%0d.f", i), f, logic_exp[i]);
      chk($sformatf("logic%0d.c_out", i), {7'b0, c_out}, 8'h00);
      chk($sformatf("logic%0d.ovf", i), {7'b0, overflow}, 8'h00);
    end
    apply(8'hFF, 8'hFF, 4'b1110, 1'b1, 1'b1);
    chk("logic_or_ff.c_out", {7'b0, c_out}, 8'h00);

    // Asynchronous reset between edges, then reload
    apply(8'h7F, 8'h01, 4'b0101, 1'b0, 1'b0);
    chk("pre_rst.f", f, 8'h80);
    a = 8'h55; b = 8'h55;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.f", f, 8'h00);
    chk("async_rst.eq", {7'b0, a_eq_b}, 8'h00);
    chk("async_rst.c_out", {7'b0, c_out}, 8'h00);
    chk("async_rst.ovf", {7'b0, overflow}, 8'h00);
    @(posedge clk);
    #1;
    chk("held_rst.f", f, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.f", f, 8'hAA);
    chk("post_rst.eq", {7'b0, a_eq_b}, 8'h01);
    chk("post_rst.c_out", {7'b0, c_out}, 8'h00);
    chk("post_rst.ovf", {7'b0, overflow}, {7'b0, OVF_EN});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ula_8bit.md
# ula_8bit

8-bit arithmetic/logic unit assembled from two cascaded 4-bit slices with ripple carry between them. It supports 16 arithmetic and 16 logic functions, selected by a 4-bit function code and a mode bit. It also provides carry-out, signed overflow and an A==B flag. All outputs are registered, so it sits as a one-stage datapath element between operand registers and the result bus.

## Interface
- No parameters; width fixed at 8 (two 4-bit slices).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a  in  8  operand A.
- b  in  8  operand B.
- s  in  4  function select.
- m  in  1  mode: 0 = arithmetic, 1 = logic.
- c_in  in  1  carry-in to low slice.
- f  out  8  result, registered.
- a_eq_b  out  1  1 when a == b, registered.
- c_out  out  1  carry out of bit 7, registered.
- overflow  out  1  two's-complement overflow, registered.

## Operation
- Arithmetic mode (m=0): every function is F = X + Y + k, with one 9-bit carry chain.
  - k = c_in unless stated otherwise below.
  - c_out = bit 8 of the sum.
  - overflow = carry into bit 7 XOR carry out of bit 7.
- Arithmetic functions by s:
  - 0000: A
  - 0001: A|B
  - 0010: A|~B
  - 0011: FF
  - 0100: A + (A&~B)
  - 0101: A + B
  - 0110: A + ~B (subtract with borrow)
  - 0111: (A&~B) + FF
  - 1000: A + ~B with k forced to 1 (A − B); c_in ignored
  - 1001: A + A
  - 1010: (A|B) + A
  - 1011: (A&B) + FF
  - 1100: B
  - 1101: (A&B) + A
  - 1110: B + ~A with k forced to 1 (B − A); c_in ignored
  - 1111: A + FF
- Logic mode (m=1), bitwise; c_out = 0 and overflow = 0.
  - 0000: ~A
  - 0001: ~(A|B)
  - 0010: ~A&B
  - 0011: 00
  - 0100: ~(A&B)
  - 0101: ~B
  - 0110: A^B
  - 0111: A&~B
  - 1000: ~A|B
  - 1001: ~(A^B)
  - 1010: B
  - 1011: A&B
  - 1100: FF
  - 1101: A|~B
  - 1110: A|B
  - 1111: A
- Carry chain:
  - Low slice handles bits 3:0 and takes k.
  - High slice handles bits 7:4 and takes the low slice's carry-out.
  - High slice drives c_out and the bit-7 carries used for overflow.
- a_eq_b: full 8-bit equality compare of A and B, independent of m, s and c_in.
- Subtraction convention: c_out = 1 means no borrow.

## Timing
- All four outputs are captured on the rising clk edge; latency is exactly 1 cycle from an input change to the registered output.
- Inputs are sampled every cycle; there is no handshake and no enable.
- Reset (rst_n low): f = 00, a_eq_b = 0, c_out = 0, overflow = 0, applied immediately regardless of clk.
- Reset asserted mid-stream discards the pending result.
- First valid result appears on the first rising edge after rst_n deasserts.
- Wrap-around is modulo 256 on f; no saturation.

## Configuration
- ULA_OVERFLOW_EN defined: overflow is computed as above.
- ULA_OVERFLOW_EN undefined: the overflow logic is omitted and the overflow output is tied to 0, including through reset.
- All other outputs are identical in both builds.

## Structure
- Package ula_pkg holds:
  - mode constants MODE_ARITH = 0 and MODE_LOGIC = 1;
  - a 4-bit enum of function codes, including FN_ADD = 0101 and FN_SUB = 1000.
- Sub-module ula_slice_4:
  - purely combinational 4-bit slice computing X/Y selection, logic functions and the 4-bit add;
  - outputs: carry-out and the carry into its MSB.
- Top module:
  - instantiates two ula_slice_4 slices;
  - forces k for functions 1000 and 1110;
  - computes overflow and a_eq_b;
  - holds the output registers.

## Test plan
- All results below appear one cycle after the inputs are applied.
- Add, m=0, s=0101, c_in=0:
  - 01+02 -> f=03, c_out=0, overflow=0.
  - 0F+01 -> f=10 (carry crosses slices).
  - 7F+01 -> f=80, overflow=1, c_out=0.
  - FF+01 -> f=00, c_out=1, overflow=0.
- Subtract, m=0, s=1000, c_in=0:
  - 0A,05 -> f=05, c_out=1, overflow=0.
  - 05,0A -> f=FB, c_out=0, overflow=0.
  - 80,01 -> f=7F, c_out=1, overflow=1.
- Compare:
  - 55,55 -> a_eq_b=1.
  - 55,54 -> a_eq_b=0.
  - 55,D5 -> a_eq_b=0.
- Logic, m=1, A=F0, B=3C:
  - s=0110 -> f=CC.
  - s=1011 -> f=30.
  - c_out and overflow stay 0 for every s.
- Reset: assert rst_n=0 between clock edges while f=80 -> all outputs 0 immediately; after release, the next edge loads the current result.
- Build without ULA_OVERFLOW_EN: 7F+01 -> f=80, overflow=0.
